pwm_duty_ctrl: RTL and testbench

Duty-cycle controller that sits in front of the 10-step PWM generator. It shares the duty setting between two requesters: the debounced increment/decrement button pulses and a host write port. Duty changes are applied only at PWM period boundaries so the output never glitches. Host writes can optionally ramp the duty one step at a time.

---
 rtl/pwm_duty_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller for the PWM generator: arbitrates button steps and host writes,
// applies duty only at period wraps. Define PWM_RAMP_EN to enable stepped host ramps.
module pwm_duty_ctrl #(
    parameter int unsigned DUTY_W    = 4,
    parameter int unsigned DUTY_MIN  = 1,
    parameter int unsigned DUTY_MAX  = 9,
    parameter int unsigned DUTY_INIT = 5,
    parameter int unsigned RAMP_DIV  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pwm_wrap,
    input  logic              i_inc_p,
    input  logic              i_dec_p,
    input  logic              i_host_req,
    input  logic [DUTY_W-1:0] i_host_duty,
    input  logic              i_host_ramp,
    output logic              o_host_ack,
    output logic [DUTY_W-1:0] o_duty,
    output logic [DUTY_W-1:0] o_target,
    output logic              o_busy,
    output logic              o_sat
);

    localparam logic [DUTY_W-1:0] L_MIN  = DUTY_MIN[DUTY_W-1:0];
    localparam logic [DUTY_W-1:0] L_MAX  = DUTY_MAX[DUTY_W-1:0];
    localparam logic [DUTY_W-1:0] L_INIT = DUTY_INIT[DUTY_W-1:0];

`ifdef PWM_RAMP_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StPend = 2'd1, StRamp = 2'd2} state_e;
    localparam logic [3:0] L_DIV_LAST = 4'(RAMP_DIV - 1);
    logic [3:0]        r_per_cnt;
    logic [DUTY_W-1:0] w_step_duty;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StPend = 2'd1} state_e;
    logic w_unused_ramp;
    assign w_unused_ramp = i_host_ramp ^ RAMP_DIV[0];
`endif

    state_e            r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic              r_host_ack;
    logic              r_busy;
    logic              r_sat;

    logic              w_host_acc;
    logic              w_host_sat;
    logic [DUTY_W-1:0] w_host_target;
    logic              w_btn_sat;
    logic              w_btn_chg;
    logic [DUTY_W-1:0] w_btn_target;

    assign w_host_acc = (r_state == StIdle) && i_host_req;

    always_comb begin
        w_host_target = i_host_duty;
        w_host_sat    = 1'b0;
        if (i_host_duty < L_MIN) begin
            w_host_target = L_MIN;
            w_host_sat    = 1'b1;
        end else if (i_host_duty > L_MAX) begin
            w_host_target = L_MAX;
            w_host_sat    = 1'b1;
        end
    end

    // Simultaneous inc and dec cancel out; steps past the limits are refused.
    always_comb begin
        w_btn_target = r_target;
        w_btn_sat    = 1'b0;
        w_btn_chg    = 1'b0;
        if (i_inc_p && !i_dec_p) begin
            if (r_target >= L_MAX) begin
                w_btn_sat = 1'b1;
            end else begin
                w_btn_target = r_target + 1'b1;
                w_btn_chg    = 1'b1;
            end
        end else if (i_dec_p && !i_inc_p) begin
            if (r_target <= L_MIN) begin
                w_btn_sat = 1'b1;
            end else begin
                w_btn_target = r_target - 1'b1;
                w_btn_chg    = 1'b1;
            end
        end
    end

`ifdef PWM_RAMP_EN
    always_comb begin
        w_step_duty = r_duty;
        if (r_duty < w_btn_target) begin
            w_step_duty = r_duty + 1'b1;
        end else if (r_duty > w_btn_target) begin
            w_step_duty = r_duty - 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_duty     <= L_INIT;
            r_target   <= L_INIT;
            r_host_ack <= 1'b0;
            r_busy     <= 1'b0;
            r_sat      <= 1'b0;
`ifdef PWM_RAMP_EN
            r_per_cnt  <= '0;
`endif
        end else begin
            r_host_ack <= 1'b0;
            r_sat      <= 1'b0;
            if (w_host_acc) begin
                // Host wins; same-cycle button pulses and wrap are dropped.
                r_target   <= w_host_target;
                r_sat      <= w_host_sat;
                r_host_ack <= 1'b1;
                r_busy     <= 1'b1;
`ifdef PWM_RAMP_EN
                r_per_cnt  <= '0;
                r_state    <= i_host_ramp ? StRamp : StPend;
`else
                r_state    <= StPend;
`endif
            end else begin
                r_target <= w_btn_target;
                r_sat    <= w_btn_sat;
                unique case (r_state)
                    StIdle: begin
                        if (w_btn_chg) begin
                            r_state <= StPend;
                            r_busy  <= 1'b1;
                        end
                    end
                    StPend: begin
                        // Use the post-button target so IDLE always holds duty == target.
                        if (i_pwm_wrap) begin
                            r_duty  <= w_btn_target;
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef PWM_RAMP_EN
                    StRamp: begin
                        if (i_pwm_wrap) begin
                            if (r_per_cnt == L_DIV_LAST) begin
                                r_per_cnt <= '0;
                                r_duty    <= w_step_duty;
                                if (w_step_duty == w_btn_target) begin
                                    r_state <= StIdle;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_per_cnt <= r_per_cnt + 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_host_ack = r_host_ack;
    assign o_duty     = r_duty;
    assign o_target   = r_target;
    assign o_busy     = r_busy;
    assign o_sat      = r_sat;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed self-checking bench for pwm_duty_ctrl; ramp checks run when PWM_RAMP_EN is defined.
module tb_pwm_duty_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_wrap = 1'b0;
    logic       inc_p = 1'b0;
    logic       dec_p = 1'b0;
    logic       host_req = 1'b0;
    logic [3:0] host_duty = 4'd0;
    logic       host_ramp = 1'b0;
    logic       host_ack;
    logic [3:0] duty;
    logic [3:0] target;
    logic       busy;
    logic       sat;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_duty_ctrl #(
        .DUTY_W   (4),
        .DUTY_MIN (1),
        .DUTY_MAX (9),
        .DUTY_INIT(5),
        .RAMP_DIV (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pwm_wrap (pwm_wrap),
        .i_inc_p    (inc_p),
        .i_dec_p    (dec_p),
        .i_host_req (host_req),
        .i_host_duty(host_duty),
        .i_host_ramp(host_ramp),
        .o_host_ack (host_ack),
        .o_duty     (duty),
        .o_target   (target),
        .o_busy     (busy),
        .o_sat      (sat)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_tgt;
        logic       exp_sat;
    } hvec_t;

    hvec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrap_tick();
        pwm_wrap = 1'b1;
        tick();
        pwm_wrap = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] prev;
        vecs[0] = '{req: 4'd2,  exp_tgt: 4'd2, exp_sat: 1'b0};
        vecs[1] = '{req: 4'd12, exp_tgt: 4'd9, exp_sat: 1'b1};
        vecs[2] = '{req: 4'd0,  exp_tgt: 4'd1, exp_sat: 1'b1};
        vecs[3] = '{req: 4'd9,  exp_tgt: 4'd9, exp_sat: 1'b0};
        vecs[4] = '{req: 4'd15, exp_tgt: 4'd9, exp_sat: 1'b1};
        vecs[5] = '{req: 4'd1,  exp_tgt: 4'd1, exp_sat: 1'b0};
        vecs[6] = '{req: 4'd5,  exp_tgt: 4'd5, exp_sat: 1'b0};

        // Reset state
        do_reset();
        tick();
        chk("rst_duty", duty, 5);
        chk("rst_target", target, 5);
        chk("rst_busy", busy, 0);
        chk("rst_ack", host_ack, 0);
        chk("rst_sat", sat, 0);

        // Three increments, then one wrap applies them all
        for (int i = 0; i < 3; i++) begin
            inc_p = 1'b1;
            tick();
            inc_p = 1'b0;
            chk("inc_target", target, 6 + i);
            chk("inc_busy", busy, 1);
            repeat (2) tick();
            chk("inc_duty_hold", duty, 5);
        end
        wrap_tick();
        chk("inc_duty_wrap", duty, 8);
        chk("inc_busy_done", busy, 0);

        // Saturation at DUTY_MAX
        inc_p = 1'b1;
        tick();
        inc_p = 1'b0;
        wrap_tick();
        chk("to9_duty", duty, 9);
        inc_p = 1'b1;
        tick();
        inc_p = 1'b0;
        chk("sat_target", target, 9);
        chk("sat_pulse", sat, 1);
        chk("sat_busy", busy, 0);
        tick();
        chk("sat_one_cycle", sat, 0);
        inc_p = 1'b1;
        dec_p = 1'b1;
        tick();
        inc_p = 1'b0;
        dec_p = 1'b0;
        chk("both_target", target, 9);
        chk("both_sat", sat, 0);
        chk("both_busy", busy, 0);

        // Host immediate writes, table-driven
        prev = 4'd9;
        for (int i = 0; i < 7; i++) begin
            host_req  = 1'b1;
            host_duty = vecs[i].req;
            host_ramp = 1'b0;
            tick();
            host_req = 1'b0;
            chk("host_ack", host_ack, 1);
            chk("host_target", target, vecs[i].exp_tgt);
            chk("host_sat", sat, vecs[i].exp_sat);
            chk("host_busy", busy, 1);
            tick();
            chk("host_ack_once", host_ack, 0);
            chk("host_duty_hold", duty, prev);
            wrap_tick();
            chk("host_duty_wrap", duty, vecs[i].exp_tgt);
            chk("host_busy_done", busy, 0);
            prev = vecs[i].exp_tgt;
        end

        // Host held off while busy, accepted once back in IDLE
        inc_p = 1'b1;
        tick();
        inc_p = 1'b0;
        host_req  = 1'b1;
        host_duty = 4'd3;
        repeat (3) begin
            tick();
            chk("holdoff_ack", host_ack, 0);
        end
        wrap_tick();
        chk("holdoff_ack_wrap", host_ack, 0);
        chk("holdoff_duty", duty, 6);
        tick();
        host_req = 1'b0;
        chk("holdoff_accept", host_ack, 1);
        chk("holdoff_target", target, 3);
        wrap_tick();
        chk("holdoff_duty2", duty, 3);

        // Host and button together: host value only
        host_req  = 1'b1;
        host_duty = 4'd7;
        inc_p     = 1'b1;
        tick();
        host_req = 1'b0;
        inc_p    = 1'b0;
        chk("arb_ack", host_ack, 1);
        chk("arb_target", target, 7);
        wrap_tick();
        chk("arb_duty", duty, 7);

        // Wrap coincident with accept is not used
        host_req  = 1'b1;
        host_duty = 4'd4;
        pwm_wrap  = 1'b1;
        tick();
        host_req = 1'b0;
        pwm_wrap = 1'b0;
        chk("wrapacc_ack", host_ack, 1);
        chk("wrapacc_duty", duty, 7);
        chk("wrapacc_busy", busy, 1);
        tick();
        chk("wrapacc_duty2", duty, 7);
        wrap_tick();
        chk("wrapacc_duty3", duty, 4);
        chk("wrapacc_busy2", busy, 0);

        do_reset();
        chk("rst2_duty", duty, 5);

`ifdef PWM_RAMP_EN
        // Ramp 5 -> 8, retargeted to 7 by dec_p after the first step
        host_req  = 1'b1;
        host_duty = 4'd8;
        host_ramp = 1'b1;
        tick();
        host_req  = 1'b0;
        host_ramp = 1'b0;
        chk("ramp_ack", host_ack, 1);
        chk("ramp_target", target, 8);
        chk("ramp_busy", busy, 1);
        for (int w = 1; w <= 8; w++) begin
            wrap_tick();
            chk("ramp_duty", duty, (w >= 8) ? 7 : ((w >= 4) ? 6 : 5));
            if (w == 4) begin
                dec_p = 1'b1;
                tick();
                dec_p = 1'b0;
                chk("ramp_retarget", target, 7);
                chk("ramp_busy_mid", busy, 1);
            end
        end
        chk("ramp_busy_done", busy, 0);

        // Reset mid-ramp with a host request pending
        host_req  = 1'b1;
        host_duty = 4'd2;
        host_ramp = 1'b1;
        tick();
        host_req  = 1'b0;
        host_ramp = 1'b0;
        repeat (4) wrap_tick();
        chk("ramp2_duty", duty, 6);
        host_req  = 1'b1;
        host_duty = 4'd9;
`else
        // host_ramp ignored: applied at the next wrap
        host_req  = 1'b1;
        host_duty = 4'd8;
        host_ramp = 1'b1;
        tick();
        host_req  = 1'b0;
        host_ramp = 1'b0;
        chk("noramp_ack", host_ack, 1);
        chk("noramp_target", target, 8);
        wrap_tick();
        chk("noramp_duty", duty, 8);
        chk("noramp_busy", busy, 0);

        // Reset mid-PEND with a host request pending
        dec_p = 1'b1;
        tick();
        dec_p = 1'b0;
        chk("pend_busy", busy, 1);
        host_req  = 1'b1;
        host_duty = 4'd9;
`endif
        rst = 1'b1;
        tick();
        chk("abort_duty", duty, 5);
        chk("abort_target", target, 5);
        chk("abort_busy", busy, 0);
        chk("abort_ack", host_ack, 0);
        host_req = 1'b0;
        rst      = 1'b0;
        tick();
        chk("abort_ack_after", host_ack, 0);
        chk("abort_duty_after", duty, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
